// File: rtl/lfsr_checker_param_if.sv
// Stream/status bundle between an LFSR source (master) and lfsr_checker_param (slave).
// Carries the qualified data word one way and the lock/error status the other.
interface lfsr_checker_param_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 i_valid;
  logic [WIDTH-1:0]     i_data;
  logic                 o_lock;
  logic                 o_err;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport master (
    output i_valid, i_data,
    input  o_lock, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_data,
    output o_lock, o_err, o_err_cnt
  );
endinterface

// File: rtl/lfsr_checker_param.sv
// Parametrised Fibonacci LFSR/PRBS checker: self-synchronises in SEARCH, free-runs its
// prediction in LOCKED, and reports per-word error pulses plus a saturating error count.
module lfsr_checker_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int               LOCK_CNT   = 5,
  parameter int               UNLOCK_CNT = 3,
  parameter int               ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_soft_reset,
  lfsr_checker_param_if.slave  bus
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] x);
    return (&x) ? x : x + ERR_CNT_W'(1);
  endfunction

  state_t               r_state;
  logic [WIDTH-1:0]     r_exp;
  logic                 r_primed;
  logic [CNT_W-1:0]     r_match_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;
  logic                 r_lock;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_match;
  logic [CNT_W-1:0]     w_match_inc;
  logic [CNT_W-1:0]     w_miss_inc;

  // An all-zero word never matches, so the LFSR lock-up state cannot produce a lock.
  always_comb begin
    w_match     = r_primed && (bus.i_data == r_exp) && (bus.i_data != '0);
    w_match_inc = r_match_cnt + CNT_W'(1);
    w_miss_inc  = r_miss_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_SEARCH;
      r_exp       <= '0;
      r_primed    <= 1'b0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_lock      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else if (i_soft_reset) begin
      r_state     <= S_SEARCH;
      r_exp       <= '0;
      r_primed    <= 1'b0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_lock      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      if (bus.i_valid) begin
        case (r_state)
          S_SEARCH: begin
            // Re-seed from every received word until the lock threshold is met.
            r_exp    <= lfsr_next(bus.i_data);
            r_primed <= 1'b1;
            if (w_match) begin
              if (w_match_inc == CNT_W'(LOCK_CNT)) begin
                r_state     <= S_LOCKED;
                r_lock      <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          S_LOCKED: begin
            // Prediction free-runs so a corrupted word cannot desynchronise it.
            r_exp <= lfsr_next(r_exp);
            if (w_match) begin
              r_miss_cnt <= '0;
            end else begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
              if (w_miss_inc == CNT_W'(UNLOCK_CNT)) begin
                r_state    <= S_SEARCH;
                r_lock     <= 1'b0;
                r_miss_cnt <= '0;
                r_primed   <= 1'b0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

  assign bus.o_lock    = r_lock;
  assign bus.o_err     = r_err;
  assign bus.o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker_param.sv
// Directed bench for lfsr_checker_param: an 8-bit default instance and a 16-bit
// instance with a 4-bit error counter for saturation.
module tb_lfsr_checker_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic srst_a;
  logic srst_b;

  lfsr_checker_param_if #(.WIDTH(8),  .ERR_CNT_W(16)) bus_a ();
  lfsr_checker_param_if #(.WIDTH(16), .ERR_CNT_W(4))  bus_b ();

  lfsr_checker_param dut_a (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_soft_reset (srst_a),
    .bus          (bus_a)
  );

  lfsr_checker_param #(
    .WIDTH     (16),
    .TAPS      (16'hB400),
    .LOCK_CNT  (5),
    .UNLOCK_CNT(3),
    .ERR_CNT_W (4)
  ) dut_b (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_soft_reset (srst_b),
    .bus          (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  gen_a;
  logic [15:0] gen_b;

  function automatic logic [7:0] nxt8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [15:0] nxt16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic v, input logic [7:0] mask);
    bus_b.i_valid = 1'b0;
    bus_a.i_valid = v;
    if (v) begin
      bus_a.i_data = gen_a ^ mask;
      gen_a = nxt8(gen_a);
    end else begin
      bus_a.i_data = 8'($urandom);
    end
    tick();
  endtask

  task automatic send_b(input logic [15:0] mask);
    bus_a.i_valid = 1'b0;
    bus_b.i_valid = 1'b1;
    bus_b.i_data  = gen_b ^ mask;
    gen_b = nxt16(gen_b);
    tick();
  endtask

  initial begin
    logic [15:0] vpat;
    int          nv;
    rst_n = 1'b0;
    srst_a = 1'b0;
    srst_b = 1'b0;
    bus_a.i_valid = 1'b0;
    bus_a.i_data  = '0;
    bus_b.i_valid = 1'b0;
    bus_b.i_data  = '0;
    tick();
    tick();
    chk("rst_lock_a", bus_a.o_lock, 0);
    chk("rst_err_a", bus_a.o_err, 0);
    chk("rst_cnt_a", bus_a.o_err_cnt, 0);
    chk("rst_lock_b", bus_b.o_lock, 0);
    chk("rst_cnt_b", bus_b.o_err_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Clean stream from seed 0xFF: prime + 5 matches
    gen_a = 8'hFF;
    for (int i = 1; i <= 6; i++) begin
      send_a(1'b1, 8'h00);
      chk("lock_rise", bus_a.o_lock, (i == 6) ? 1 : 0);
    end
    for (int i = 7; i <= 300; i++) begin
      send_a(1'b1, 8'h00);
      chk("clean_err", bus_a.o_err, 0);
    end
    chk("clean_lock", bus_a.o_lock, 1);
    chk("clean_cnt", bus_a.o_err_cnt, 0);

    // Single corrupted word
    send_a(1'b1, 8'h01);
    chk("single_err", bus_a.o_err, 1);
    chk("single_cnt", bus_a.o_err_cnt, 1);
    chk("single_lock", bus_a.o_lock, 1);
    for (int i = 0; i < 10; i++) begin
      send_a(1'b1, 8'h00);
      chk("post_single_err", bus_a.o_err, 0);
    end
    chk("post_single_cnt", bus_a.o_err_cnt, 1);

    // Three consecutive errors force SEARCH
    for (int i = 1; i <= 3; i++) begin
      send_a(1'b1, 8'h80);
      chk("burst_err", bus_a.o_err, 1);
      chk("burst_lock", bus_a.o_lock, (i == 3) ? 0 : 1);
    end
    chk("burst_cnt", bus_a.o_err_cnt, 4);
    for (int i = 1; i <= 6; i++) begin
      send_a(1'b1, 8'h00);
      chk("relock", bus_a.o_lock, (i == 6) ? 1 : 0);
      chk("relock_err", bus_a.o_err, 0);
    end
    chk("relock_cnt", bus_a.o_err_cnt, 4);

    // Soft reset wins over a simultaneous valid word
    srst_a = 1'b1;
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = gen_a;
    gen_a = nxt8(gen_a);
    tick();
    srst_a = 1'b0;
    chk("srst_lock", bus_a.o_lock, 0);
    chk("srst_cnt", bus_a.o_err_cnt, 0);
    chk("srst_err", bus_a.o_err, 0);

    // Gapped valid with garbage in the gaps
    vpat = 16'b1011_0010_1101_0110;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      send_a(vpat[i], 8'h00);
      if (vpat[i]) nv++;
      chk("gap_lock", bus_a.o_lock, (nv >= 6) ? 1 : 0);
      chk("gap_err", bus_a.o_err, 0);
    end

    // Async reset mid-cycle clears outputs immediately
    send_a(1'b1, 8'h04);
    chk("pre_arst_err", bus_a.o_err, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_lock", bus_a.o_lock, 0);
    chk("arst_err", bus_a.o_err, 0);
    chk("arst_cnt", bus_a.o_err_cnt, 0);
    tick();
    rst_n = 1'b1;

    // All-zero stream never locks nor counts
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 8'h00;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("zero_lock", bus_a.o_lock, 0);
    end
    chk("zero_cnt", bus_a.o_err_cnt, 0);
    for (int i = 1; i <= 6; i++) begin
      send_a(1'b1, 8'h00);
      chk("zero_relock", bus_a.o_lock, (i == 6) ? 1 : 0);
    end

    // 16-bit instance: lock, then 20 spaced errors saturate at 15
    gen_b = 16'hACE1;
    for (int i = 1; i <= 6; i++) begin
      send_b(16'h0000);
      chk("b_lock", bus_b.o_lock, (i == 6) ? 1 : 0);
    end
    for (int k = 1; k <= 20; k++) begin
      send_b(16'h0001);
      chk("b_err", bus_b.o_err, 1);
      chk("b_cnt", bus_b.o_err_cnt, (k > 15) ? 15 : k);
      send_b(16'h0000);
      chk("b_gap_err", bus_b.o_err, 0);
    end
    chk("b_sat_lock", bus_b.o_lock, 1);
    chk("b_sat_cnt", bus_b.o_err_cnt, 15);
    chk("a_untouched", bus_a.o_err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
